// File: rtl/in_debounce_pkg.sv
// Shared types and default constants for the two-channel input debouncer.
package in_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b10,
    PEND_LO   = 2'b11
  } deb_state_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 3;

endpackage

// File: rtl/deb_chan.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with a
// pending counter, registered level output and registered edge strobes.
module deb_chan
  import in_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, s_q;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Bring the asynchronous raw line into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
    end
  end

  // Next state / counter; level and strobes derive from the next state so
  // the registered level lands on the same edge as the state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      STABLE_LO: if (s_q) begin
        state_d = PEND_HI;
        cnt_d   = CNT_W'(1);
      end
      PEND_HI: begin
        if (!s_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: if (!s_q) begin
        state_d = PEND_LO;
        cnt_d   = CNT_W'(1);
      end
      PEND_LO: begin
        if (s_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    lvl_d  = (state_d == STABLE_HI) || (state_d == PEND_LO);
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl  = lvl_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/in_debounce.sv
// Two independent debounce channels plus a start-up counter that raises
// 'settled' in step with the earliest possible valid debounced level.
module in_debounce
  import in_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw1,
  input  logic raw2,
  output logic in1,
  output logic in2,
  output logic in1_rise,
  output logic in1_fall,
  output logic in2_rise,
  output logic in2_fall,
  output logic settled
);

  // One extra bit so the start-up target DEB_CYCLES+2 always fits.
  localparam int             SU_W   = CNT_W + 1;
  localparam logic [SU_W-1:0] SU_MAX = SU_W'(DEB_CYCLES + 2);

  logic [SU_W-1:0] su_cnt_q, su_cnt_d;
  logic            settled_q, settled_d;

  deb_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan1 (
    .clk(clk), .reset_n(reset_n), .raw(raw1),
    .lvl(in1), .rise(in1_rise), .fall(in1_fall)
  );

  deb_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_chan2 (
    .clk(clk), .reset_n(reset_n), .raw(raw2),
    .lvl(in2), .rise(in2_rise), .fall(in2_fall)
  );

  // Saturating count of edges since reset release.
  always_comb begin
    su_cnt_d  = (su_cnt_q == SU_MAX) ? su_cnt_q : su_cnt_q + SU_W'(1);
    settled_d = (su_cnt_d == SU_MAX);
  end

  // Start-up counter and registered settled flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      su_cnt_q  <= '0;
      settled_q <= 1'b0;
    end else begin
      su_cnt_q  <= su_cnt_d;
      settled_q <= settled_d;
    end
  end

  assign settled = settled_q;

endmodule

// File: tb/tb_in_debounce.sv
// Directed self-checking bench for in_debounce at default parameters.
module tb_in_debounce;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw1 = 1'b0;
  logic raw2 = 1'b0;
  logic in1, in2, in1_rise, in1_fall, in2_rise, in2_fall, settled;

  int errors = 0;
  int checks = 0;

  in_debounce dut (
    .clk(clk), .reset_n(reset_n), .raw1(raw1), .raw2(raw2),
    .in1(in1), .in2(in2),
    .in1_rise(in1_rise), .in1_fall(in1_fall),
    .in2_rise(in2_rise), .in2_fall(in2_fall),
    .settled(settled)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset_n = 1'b0; raw1 = 1'b0; raw2 = 1'b0;
    #3;
    obs = {in1, in2, in1_rise, in1_fall, in2_rise, in2_fall, settled};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, 7'b0);
    end
    tick(); tick();
    reset_n = 1'b1;
    // next posedge is edge 0 after release; settled after edge 5 (tick 6)
    for (int t = 1; t <= 20; t++) begin
      tick();
      obs = {in1, in2, in1_rise, in1_fall, in2_rise, in2_fall, settled};
      checks++;
      if (obs !== {6'b0, (t >= 6) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL idle_settled t=%0d got=%b exp=%b", t, obs, {6'b0, t >= 6});
      end
    end
  endtask

  task automatic test_rise();
    logic [3:0] obs, exp;
    raw1 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      obs = {in1, in1_rise, in2, in2_rise | in2_fall};
      exp = {(t >= 6) ? 1'b1 : 1'b0, (t == 6) ? 1'b1 : 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rise_latency t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
    raw1 = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      obs = {in1, in1_fall, 2'b00};
      exp = {(t >= 6) ? 1'b0 : 1'b1, (t == 6) ? 1'b1 : 1'b0, 2'b00};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fall_latency t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    int rises, falls, hi_at6;
    for (int n = 3; n <= 4; n++) begin
      rises = 0; falls = 0; hi_at6 = 0;
      for (int t = 1; t <= 14; t++) begin
        raw1 = (t <= n) ? 1'b1 : 1'b0;
        tick();
        if (in1_rise) rises++;
        if (in1_fall) falls++;
        if (t == 6 && in1) hi_at6 = 1;
      end
      checks++;
      if (rises !== n - 3 || falls !== n - 3 || hi_at6 !== n - 3 || in1 !== 1'b0) begin
        errors++;
        $display("FAIL glitch_n%0d rises=%0d falls=%0d hi_at6=%0d in1=%b exp=%0d/%0d/%0d/0",
                 n, rises, falls, hi_at6, in1, n - 3, n - 3, n - 3);
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] seq;
    int falls, first, rises, early_lo;
    raw2 = 1'b1;
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if (in2 !== 1'b1) begin
      errors++;
      $display("FAIL bounce_setup in2=%b exp=1", in2);
    end
    seq = 7'b0000101; // applied LSB first: 1,0,1,0,0,0,0
    falls = 0; first = 0; rises = 0; early_lo = 0;
    for (int t = 1; t <= 14; t++) begin
      raw2 = (t <= 7) ? seq[t-1] : 1'b0;
      tick();
      if (in2_fall) begin
        falls++;
        if (first == 0) first = t;
      end
      if (in2_rise) rises++;
      if (t < 9 && in2 !== 1'b1) early_lo = 1;
    end
    checks++;
    if (falls !== 1 || first !== 9 || rises !== 0 || early_lo !== 0 || in2 !== 1'b0) begin
      errors++;
      $display("FAIL bounce falls=%0d first=%0d rises=%0d early_lo=%0d in2=%b exp=1/9/0/0/0",
               falls, first, rises, early_lo, in2);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] obs, exp;
    raw1 = 1'b1; raw2 = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      obs = {in1_rise, in2_rise};
      exp = (t == 6) ? 2'b11 : 2'b00;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL simul_rise t=%0d got=%b exp=%b", t, obs, exp);
      end
    end
    raw1 = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    // raw2 stays high: in2=1 for the mid-operation reset test
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs;
    logic [3:0] o2, e2;
    raw1 = 1'b1;
    for (int t = 0; t < 4; t++) tick(); // channel 1 now PEND_HI, cnt=2
    checks++;
    if ({in1, in2, settled} !== 3'b011) begin
      errors++;
      $display("FAIL premid got=%b exp=011", {in1, in2, settled});
    end
    reset_n = 1'b0;
    #2;
    obs = {in1, in2, in1_rise, in1_fall, in2_rise, in2_fall, settled};
    checks++;
    if (obs !== 7'b0) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b", obs, 7'b0);
    end
    tick();
    reset_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      o2 = {in1, in1_rise, in2, settled};
      e2 = (t >= 6) ? {1'b1, (t == 6) ? 1'b1 : 1'b0, 1'b1, 1'b1} : 4'b0;
      checks++;
      if (o2 !== e2) begin
        errors++;
        $display("FAIL post_reset t=%0d got=%b exp=%b", t, o2, e2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/in_debounce.md
# in_debounce

Input-conditioning stage directly upstream of the two-input Mealy controller. It takes two asynchronous, possibly bouncing raw lines and delivers clean, glitch-free `in1`/`in2` levels in the `clk` domain, plus one-cycle edge strobes. It also provides a `settled` flag so that downstream logic can ignore the start-up window.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive synchronized samples of a new level required before the output changes. Legal range 2..2^CNT_W−1.
- `CNT_W`, default 3: width of each channel's debounce counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. It clears all state immediately when asserted.
- `raw1`  in  1  asynchronous raw input, channel 1.
- `raw2`  in  1  asynchronous raw input, channel 2.
- `in1`  out  1  debounced level, channel 1. Reset value 0.
- `in2`  out  1  debounced level, channel 2. Reset value 0.
- `in1_rise`, `in1_fall`  out  1 each  one-cycle strobes marking a change of `in1`. Reset value 0.
- `in2_rise`, `in2_fall`  out  1 each  one-cycle strobes marking a change of `in2`. Reset value 0.
- `settled`  out  1  high once the start-up window has elapsed. Reset value 0.

## Operation
- Each raw line passes through a 2-flop synchronizer, both flops reset to 0. The second flop is the sample `s`.
- Each channel runs an independent 4-state FSM with a counter `cnt`.
  - STABLE_LO: output 0. If `s`=1, go to PEND_HI with `cnt`=1.
  - PEND_HI: output 0.
    - If `s`=0, return to STABLE_LO with `cnt`=0. This rejects a glitch.
    - If `s`=1 and `cnt`=DEB_CYCLES−1, go to STABLE_HI with `cnt`=0.
    - Otherwise, increment `cnt`.
  - STABLE_HI: output 1. If `s`=0, go to PEND_LO with `cnt`=1.
  - PEND_LO: output 1.
    - If `s`=1, return to STABLE_HI with `cnt`=0.
    - If `s`=0 and `cnt`=DEB_CYCLES−1, go to STABLE_LO with `cnt`=0.
    - Otherwise, increment `cnt`.
- The output level is registered and is a pure function of the state: 1 in STABLE_HI and PEND_LO, 0 otherwise.
- `inX_rise` is registered and asserts for exactly one cycle, in the same cycle that `inX` first reads 1. `inX_fall` behaves the same way for the change to 0.
- `cnt` never exceeds DEB_CYCLES−1. No wrap-around is possible.
- Start-up counter:
  - Counts clock edges after `reset_n` deasserts.
  - `settled` rises once the counter reaches DEB_CYCLES+2, then holds at 1.
  - The counter saturates at that value and does not wrap.
- Both channels are fully independent. Simultaneous transitions on both channels are legal, and their strobes may coincide.
- A `reset_n` assertion in mid-operation, including during a PEND state, immediately forces:
  - all states to STABLE_LO,
  - all outputs and strobes to 0,
  - `settled` to 0.

## Timing
- Latency: a raw level held stable from before rising edge 0 appears on `inX` after edge DEB_CYCLES+1. That is DEB_CYCLES+2 edges; 6 edges at the default.
- Strobes are visible in the same cycle as the new level.
- A pulse on `s` lasting fewer than DEB_CYCLES samples produces no output change and no strobe.
- A pulse of exactly DEB_CYCLES samples is accepted.
- Raw toggle rate faster than 1/DEB_CYCLES: the output holds its last stable level.
- `settled` rises after edge DEB_CYCLES+1 following reset release, so that it aligns with the earliest possible valid `inX`.

## Structure
- Shared package `in_debounce_pkg` contains:
  - the state typedef `deb_state_t`, 2 bits: STABLE_LO=00, PEND_HI=01, STABLE_HI=10, PEND_LO=11;
  - default constants for DEB_CYCLES and CNT_W.
- Sub-module `deb_chan`: one channel, comprising the synchronizer, FSM, counter, level output and rise/fall strobes. The top level instantiates it twice and adds the start-up counter.

## Test plan
- Reset, then `raw1`=`raw2`=0 for 20 cycles -> `in1`=`in2`=0, no strobes, `settled`=1 from the cycle after edge 5.
- `raw1` 0→1 held, DEB_CYCLES=4 -> `in1`=1 after edge 5 following the change, `in1_rise` high for exactly 1 cycle, `in2` unaffected.
- `raw1` high for 3 samples, then low -> `in1` stays 0, no strobe. Repeat with 4 samples -> `in1` goes to 1.
- From `in2`=1, `raw2` bounces 1,0,1,0,0,0,0 -> one `in2_fall` only, at the earliest after the 4th consecutive 0 sample.
- Both raws toggle on the same edge -> `in1_rise` and `in2_rise` assert in the same cycle.
- Assert `reset_n` while channel 1 is in PEND_HI with `cnt`=2 -> all outputs 0 immediately. After release, a new transition needs the full DEB_CYCLES+2 edges again.
